// File: rtl/day017_sdp_stream_fifo.sv
// day017_sdp_stream_fifo: valid/ready FIFO over a simple dual-port array with a registered first-word-fall-through output stage
module day017_sdp_stream_fifo #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int DEPTH       = 8,
  parameter  int ALMOST_FULL = 6,
  localparam int ADDR_WIDTH  = $clog2(DEPTH),
  localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, ram_cnt;
  logic                  s_ready_q, m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  push, pop, re;
  always_comb begin
    push      = s_valid_i & s_ready_q;
    pop       = m_valid_q & m_ready_i;
    ram_cnt   = count_q - CNT_WIDTH'(m_valid_q);
    // ram_cnt != 0 keeps the read slot distinct from the slot being written
    re        = (ram_cnt != '0) & (~m_valid_q | m_ready_i);
    count_d   = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    wr_ptr_d  = push ? (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d  = re ? (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    m_valid_d = re | (m_valid_q & ~pop);
    m_data_d  = re ? mem_q[rd_ptr_q] : m_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_ready_q <= count_d != CNT_WIDTH'(DEPTH);
    end
  end
  assign s_ready_o     = s_ready_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign count_o       = count_q;
  assign empty_o       = count_q == '0;
  assign full_o        = count_q == CNT_WIDTH'(DEPTH);
  assign almost_full_o = count_q >= CNT_WIDTH'(ALMOST_FULL);
endmodule
